aes_key_expand_seq: RTL and testbench

- Sequential AES key-expansion engine, directly upstream of the decipher/cipher round datapath.
- Takes a 128/192/256-bit cipher key and produces the full round-key schedule at one 32-bit word per clock.
- Presents the schedule on a flat `words` bus in the exact layout the round stage indexes; round key r sits at `words[128*r +: 128]`.
- Asserts `key_ready` when the whole schedule is valid.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_key_expand_seq.sv | 131 +++++++++++++
 tb/tb_aes_key_expand_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: round-constant table, key-size derivations and
// key-expansion FSM state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Rcon[1..10]; entry 0 here is Rcon[1].
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int key_nk(input int x);
        return 4 + 2 * x;
    endfunction

    function automatic int key_nr(input int x);
        return 10 + 2 * x;
    endfunction

    function automatic int key_nw(input int x);
        return 4 * (key_nr(x) + 1);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational. Also usable by the
// cipher's sub-bytes stage.
module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_out = SBOX[i_in];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per clock.
// Optional KEYEXP_ZEROIZE_EN clears the whole schedule on an accepted start.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int x = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [0:128+64*x-1]        key,
    output logic [0:128*(2*x+11)-1]    words,
    output logic                       busy,
    output logic                       key_ready,
    output logic [1:0]                 o_dbg_state
);

    localparam int         NK      = key_nk(x);
    localparam int         NW      = key_nw(x);
    localparam int         KW      = 32 * NK;
    localparam logic [5:0] NK_I    = 6'(NK);
    localparam logic [5:0] LAST_I  = 6'(NW - 1);
    localparam logic [2:0] NK_POS  = 3'(NK - 1);

    state_t       r_state;
    logic [0:KW-1] r_key;
    logic [31:0]  r_w [NW];
    logic [5:0]   r_i;
    logic [2:0]   r_pos;   // i mod Nk
    logic [3:0]   r_grp;   // i / Nk
    logic         r_busy;
    logic         r_ready;

    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub;
    logic [31:0]  w_temp;
    logic [31:0]  w_next;

    assign w_prev   = r_w[r_i - 6'd1];
    assign w_back   = r_w[r_i - NK_I];
    assign w_rot    = {w_prev[23:0], w_prev[31:24]};
    // One SubWord serves both the group-start and the AES-256 mid-group paths.
    assign w_sub_in = (r_pos == 3'd0) ? w_rot : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .i_in  (w_sub_in[8*b +: 8]),
            .o_out (w_sub[8*b +: 8])
        );
    end

    always_comb begin
        w_temp = w_prev;
        if (r_pos == 3'd0) begin
            w_temp = w_sub ^ {RCON[r_grp - 4'd1], 24'h0};
        end else if (x == 2 && r_pos == 3'd4) begin
            w_temp = w_sub;
        end
    end

    assign w_next = w_back ^ w_temp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_i     <= '0;
            r_pos   <= '0;
            r_grp   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            for (int n = 0; n < NW; n++) begin
                r_w[n] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_key   <= key;
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
                        for (int n = 0; n < NW; n++) begin
                            r_w[n] <= '0;
                        end
`endif
                    end
                end
                ST_LOAD: begin
                    for (int n = 0; n < NK; n++) begin
                        r_w[n] <= r_key[32*n +: 32];
                    end
                    r_i     <= NK_I;
                    r_pos   <= 3'd0;
                    r_grp   <= 4'd1;
                    r_state <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    r_w[r_i] <= w_next;
                    if (r_i == LAST_I) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_i <= r_i + 6'd1;
                        if (r_pos == NK_POS) begin
                            r_pos <= 3'd0;
                            r_grp <= r_grp + 4'd1;
                        end else begin
                            r_pos <= r_pos + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NW; g++) begin : g_words
        assign words[32*g +: 32] = r_w[g];
    end

    assign busy        = r_busy;
    assign key_ready   = r_ready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: one instance per key size, checked against a
// FIPS-197 reference model with an S-box derived from GF(2^8) inversion.
module tb_aes_key_expand_seq;
    import aes_pkg::*;

    logic         clk;
    logic         reset;
    logic [2:0]   start;
    logic [0:255] key_in;
    logic [0:1407] words0;
    logic [0:1663] words1;
    logic [0:1919] words2;
    logic [2:0]   busy;
    logic [2:0]   ready;
    logic [1:0]   dbg0, dbg1, dbg2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  sb_ref [256];
    logic [31:0] exp_w  [60];

    typedef struct {
        int          x;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    aes_key_expand_seq #(.x(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .key(key_in[0:127]),
        .words(words0), .busy(busy[0]), .key_ready(ready[0]), .o_dbg_state(dbg0)
    );
    aes_key_expand_seq #(.x(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .key(key_in[0:191]),
        .words(words1), .busy(busy[1]), .key_ready(ready[1]), .o_dbg_state(dbg1)
    );
    aes_key_expand_seq #(.x(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .key(key_in),
        .words(words2), .busy(busy[2]), .key_ready(ready[2]), .o_dbg_state(dbg2)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] b);
        logic [7:0] inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gf_mul(inv, b);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
    endfunction

    function automatic void expand_ref(input int xs, input logic [0:255] k);
        int nk = 4 + 2 * xs;
        int nw = 4 * (11 + 2 * xs);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int j = 0; j < nk; j++) exp_w[j] = k[32*j +: 32];
        for (int i = nk; i < nw; i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endfunction

    function automatic logic [31:0] get_word(input int xs, input int i);
        case (xs)
            0:       return words0[32*i +: 32];
            1:       return words1[32*i +: 32];
            default: return words2[32*i +: 32];
        endcase
    endfunction

    function automatic logic [1:0] get_state(input int xs);
        case (xs)
            0:       return dbg0;
            1:       return dbg1;
            default: return dbg2;
        endcase
    endfunction

    // scoreboard helpers
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_sched(input int xs, input string nm);
        int nw = 4 * (11 + 2 * xs);
        for (int i = 0; i < nw; i++)
            check($sformatf("%s x%0d w[%0d]", nm, xs, i), 64'(get_word(xs, i)), 64'(exp_w[i]));
    endtask

    // driver tasks; all start and end 1 time unit after a rising edge
    task automatic pulse_start(input int xs, input logic [0:255] k);
        key_in    = k;
        start[xs] = 1'b1;
        @(posedge clk); #1;
        start[xs] = 1'b0;
    endtask

    task automatic wait_ready(input int xs, input string nm);
        int c;
        int lat = 1 + 4 * (11 + 2 * xs) - (4 + 2 * xs);
        for (c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 1) check($sformatf("%s busy after accept", nm), 64'(busy[xs]), 64'd1);
            if (ready[xs]) break;
        end
        check($sformatf("%s x%0d latency", nm, xs), 64'(c), 64'(lat));
        check($sformatf("%s busy in done", nm), 64'(busy[xs]), 64'd0);
    endtask

    task automatic run_and_check(input int xs, input logic [0:255] k, input string nm);
        pulse_start(xs, k);
        check($sformatf("%s ready low after accept", nm), 64'(ready[xs]), 64'd0);
        wait_ready(xs, nm);
        expand_ref(xs, k);
        check_sched(xs, nm);
    endtask

    function automatic logic [0:255] rand_key();
        logic [0:255] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    localparam logic [0:255] KEY0 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] KEY1 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] KEY2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        vec_t         vecs [10];
        logic [0:255] keys [3];
        logic [0:255] k_new;
        logic [31:0]  exp43, exp0;
        int           c;
        int           nz;

        for (int b = 0; b < 256; b++) sb_ref[b] = sbox_math(8'(b));

        keys[0] = KEY0; keys[1] = KEY1; keys[2] = KEY2;
        vecs[0] = '{0, 4,  32'ha0fafe17};
        vecs[1] = '{0, 40, 32'hd014f9a8};
        vecs[2] = '{0, 41, 32'hc9ee2589};
        vecs[3] = '{0, 42, 32'he13f0cc8};
        vecs[4] = '{0, 43, 32'hb6630ca6};
        vecs[5] = '{1, 6,  32'hfe0c91f7};
        vecs[6] = '{1, 51, 32'h01002202};
        vecs[7] = '{2, 8,  32'h9ba35411};
        vecs[8] = '{2, 12, 32'ha8b09c1a};
        vecs[9] = '{2, 59, 32'h706c631e};

        // reset
        reset  = 1'b1;
        start  = 3'b000;
        key_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int xs = 0; xs < 3; xs++) begin
            check($sformatf("reset state x%0d", xs), 64'(get_state(xs)), 64'(2'(ST_IDLE)));
            check($sformatf("reset busy x%0d", xs), 64'(busy[xs]), 64'd0);
            check($sformatf("reset ready x%0d", xs), 64'(ready[xs]), 64'd0);
        end
        check("reset words0 zero", 64'(words0 == '0), 64'd1);

        // known-answer table, plus full schedule against the model
        for (int xs = 0; xs < 3; xs++) begin
            run_and_check(xs, keys[xs], "kat");
            for (int v = 0; v < 10; v++)
                if (vecs[v].x == xs)
                    check($sformatf("kat x%0d w[%0d]", xs, vecs[v].idx),
                          64'(get_word(xs, vecs[v].idx)), 64'(vecs[v].exp));
        end

        // restart from DONE: old/zero contents visible until rewritten
        k_new = rand_key();
`ifdef KEYEXP_ZEROIZE_EN
        exp43 = 32'h0;
        exp0  = 32'h0;
`else
        exp43 = 32'hb6630ca6;
        exp0  = 32'h2b7e1516;
`endif
        pulse_start(0, k_new);
        check("restart ready drop", 64'(ready[0]), 64'd0);
        check("restart w[0] at accept", 64'(get_word(0, 0)), 64'(exp0));
        check("restart w[43] at accept", 64'(get_word(0, 43)), 64'(exp43));
        for (c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c < 41) check($sformatf("restart w[43] c%0d", c), 64'(get_word(0, 43)), 64'(exp43));
            if (ready[0]) break;
        end
        check("restart latency", 64'(c), 64'd41);
        expand_ref(0, k_new);
        check_sched(0, "restart");

        // randomized keys for every size
        for (int r = 0; r < 3; r++)
            for (int xs = 0; xs < 3; xs++)
                run_and_check(xs, rand_key(), $sformatf("rand%0d", r));

        // second start while busy must be ignored
        k_new = rand_key();
        pulse_start(0, KEY0);
        for (c = 1; c <= 200; c++) begin
            if (c == 10) begin
                key_in   = k_new;
                start[0] = 1'b1;
            end else begin
                start[0] = 1'b0;
            end
            @(posedge clk); #1;
            if (ready[0]) break;
        end
        start[0] = 1'b0;
        check("ignore latency", 64'(c), 64'd41);
        expand_ref(0, KEY0);
        check_sched(0, "ignore");

        // reset together with start mid-expansion
        pulse_start(0, KEY0);
        repeat (19) begin
            @(posedge clk); #1;
        end
        reset    = 1'b1;
        start[0] = 1'b1;
        key_in   = rand_key();
        @(posedge clk); #1;
        reset    = 1'b0;
        start[0] = 1'b0;
        check("midreset state", 64'(dbg0), 64'(2'(ST_IDLE)));
        check("midreset busy", 64'(busy[0]), 64'd0);
        check("midreset ready", 64'(ready[0]), 64'd0);
        nz = 0;
        for (int i = 0; i < 44; i++) if (get_word(0, i) != 32'h0) nz++;
        check("midreset nonzero words", 64'(nz), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midreset stays idle", 64'(dbg0), 64'(2'(ST_IDLE)));
        run_and_check(0, rand_key(), "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
